// File: rtl/seq_alu_pkg.sv
// seq_alu shared definitions.
// Opcodes, FSM states and flag bit positions.
package alu_pkg;

  localparam logic [4:0] OP_NOP   = 5'd0;
  localparam logic [4:0] OP_WRITE = 5'd1;
  localparam logic [4:0] OP_READ  = 5'd2;
  localparam logic [4:0] OP_COPY  = 5'd3;
  localparam logic [4:0] OP_NOT   = 5'd4;
  localparam logic [4:0] OP_AND   = 5'd5;
  localparam logic [4:0] OP_OR    = 5'd6;
  localparam logic [4:0] OP_XOR   = 5'd7;
  localparam logic [4:0] OP_NAND  = 5'd8;
  localparam logic [4:0] OP_NOR   = 5'd9;
  localparam logic [4:0] OP_ADD   = 5'd10;
  localparam logic [4:0] OP_SUB   = 5'd11;
  localparam logic [4:0] OP_ADDI  = 5'd12;
  localparam logic [4:0] OP_SUBI  = 5'd13;
  localparam logic [4:0] OP_SHL   = 5'd14;
  localparam logic [4:0] OP_SHR   = 5'd15;
  localparam logic [4:0] OP_ASR   = 5'd16;
  localparam logic [4:0] OP_ROL   = 5'd17;
  localparam logic [4:0] OP_ROR   = 5'd18;
  localparam logic [4:0] OP_MUL   = 5'd19;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_MUL
  } state_t;

  localparam int FLG_ZERO  = 0;
  localparam int FLG_NEG   = 1;
  localparam int FLG_CARRY = 2;
  localparam int FLG_OVF   = 3;
  localparam int FLG_ILL   = 4;
  localparam int FLG_N     = 5;

endpackage

// File: rtl/seq_alu_if.sv
// seq_alu request/result bundle.
// master issues operations, slave is the ALU.
interface seq_alu_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [4:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic             zero;
  logic             negative;
  logic             carry;
  logic             overflow;
  logic             illegal;

  modport master (
    output start, op, a, b,
    input  busy, done, result, result_hi,
    input  zero, negative, carry, overflow, illegal
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result, result_hi,
    output zero, negative, carry, overflow, illegal
  );
endinterface

// File: rtl/seq_alu_addsub.sv
// addsub_w: combinational add/subtract.
// o_carry is carry-out on add and borrow (a<b) on subtract.
module addsub_w #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_sub,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_carry,
  output logic             o_ovf
);
  logic [WIDTH-1:0] w_b;
  logic [WIDTH:0]   w_full;

  assign w_b    = i_sub ? ~i_b : i_b;
  assign w_full = {1'b0, i_a} + {1'b0, w_b}
                + {{WIDTH{1'b0}}, i_sub};
  assign o_sum   = w_full[WIDTH-1:0];
  assign o_carry = w_full[WIDTH] ^ i_sub;
  assign o_ovf   = (i_a[WIDTH-1] == w_b[WIDTH-1])
                && (o_sum[WIDTH-1] != i_a[WIDTH-1]);
endmodule

// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU with start/busy/done handshake.
// Logic/add ops finish in IDLE; shifts and MUL iterate a bit per cycle.
module seq_alu #(
  parameter int WIDTH = 8
) (
  input  logic     clk,
  input  logic     rst,
  seq_alu_if.slave io
);
  import alu_pkg::*;

  localparam int SH_W  = $clog2(WIDTH);
  localparam int CNT_W = SH_W + 1;
  localparam logic [WIDTH-1:0] W_LIM    = WIDTH'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);

  state_t           r_state, w_state_nxt;
  logic [4:0]       r_op, w_op_nxt;
  logic [WIDTH-1:0] r_a, w_a_nxt;
  logic [WIDTH-1:0] r_w, w_w_nxt;
  logic [WIDTH-1:0] r_hi, w_hi_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0] r_result, w_res_nxt;
  logic [WIDTH-1:0] r_result_hi, w_reshi_nxt;
  logic [FLG_N-1:0] r_flags, w_flags_nxt;
  logic             r_done, w_done_nxt;

  logic             w_in_mul;
  logic [WIDTH-1:0] w_as_a, w_as_b, w_sum;
  logic             w_as_sub, w_cy, w_ov;
  logic [WIDTH-1:0] w_mhi, w_mlo;
  logic [WIDTH-1:0] w_sh;
  logic             w_sh_c;
  logic [CNT_W-1:0] w_n;

  logic             w_fin;
  logic [WIDTH-1:0] w_fres, w_fhi;
  logic             w_fc, w_fv, w_fill;

  // One adder serves both the single-cycle ops and the MUL accumulator
  assign w_in_mul = (r_state == ST_MUL);
  assign w_as_a   = w_in_mul ? r_hi : io.a;
  assign w_as_b   = w_in_mul ? (r_w[0] ? r_a : '0) : io.b;
  assign w_as_sub = !w_in_mul
                 && (io.op == OP_SUB || io.op == OP_SUBI);

  addsub_w #(.WIDTH(WIDTH)) u_addsub (
    .i_a     (w_as_a),
    .i_b     (w_as_b),
    .i_sub   (w_as_sub),
    .o_sum   (w_sum),
    .o_carry (w_cy),
    .o_ovf   (w_ov)
  );

  assign w_mhi = {w_cy, w_sum[WIDTH-1:1]};
  assign w_mlo = {w_sum[0], r_w[WIDTH-1:1]};

  always_comb begin
    w_n = {1'b0, io.b[SH_W-1:0]};
    if ((io.op == OP_SHL || io.op == OP_SHR
        || io.op == OP_ASR) && io.b >= W_LIM)
      w_n = CNT_FULL;
  end

  always_comb begin
    w_sh   = r_w;
    w_sh_c = 1'b0;
    unique case (r_op)
      OP_SHL: begin
        w_sh   = {r_w[WIDTH-2:0], 1'b0};
        w_sh_c = r_w[WIDTH-1];
      end
      OP_SHR: begin
        w_sh   = {1'b0, r_w[WIDTH-1:1]};
        w_sh_c = r_w[0];
      end
      OP_ASR: begin
        w_sh   = {r_w[WIDTH-1], r_w[WIDTH-1:1]};
        w_sh_c = r_w[0];
      end
      OP_ROL: begin
        w_sh   = {r_w[WIDTH-2:0], r_w[WIDTH-1]};
        w_sh_c = r_w[WIDTH-1];
      end
      OP_ROR: begin
        w_sh   = {r_w[0], r_w[WIDTH-1:1]};
        w_sh_c = r_w[0];
      end
      default: ;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_op_nxt    = r_op;
    w_a_nxt     = r_a;
    w_w_nxt     = r_w;
    w_hi_nxt    = r_hi;
    w_cnt_nxt   = r_cnt;
    w_res_nxt   = r_result;
    w_reshi_nxt = r_result_hi;
    w_flags_nxt = r_flags;
    w_done_nxt  = 1'b0;
    w_fin       = 1'b0;
    w_fres      = '0;
    w_fhi       = '0;
    w_fc        = 1'b0;
    w_fv        = 1'b0;
    w_fill      = 1'b0;
    unique case (r_state)
      ST_IDLE: if (io.start) begin
        w_fin = 1'b1;
        unique case (io.op)
          OP_NOP:   w_fres = '0;
          OP_WRITE: w_fres = io.b;
          OP_READ,
          OP_COPY:  w_fres = io.a;
          OP_NOT:   w_fres = ~io.a;
          OP_AND:   w_fres = io.a & io.b;
          OP_OR:    w_fres = io.a | io.b;
          OP_XOR:   w_fres = io.a ^ io.b;
          OP_NAND:  w_fres = ~(io.a & io.b);
          OP_NOR:   w_fres = ~(io.a | io.b);
          OP_ADD, OP_SUB,
          OP_ADDI, OP_SUBI: begin
            w_fres = w_sum;
            w_fc   = w_cy;
            w_fv   = w_ov;
          end
          OP_SHL, OP_SHR, OP_ASR,
          OP_ROL, OP_ROR: begin
            // zero-length shift completes without leaving IDLE
            w_fres = io.a;
            if (w_n != '0) begin
              w_fin       = 1'b0;
              w_state_nxt = ST_SHIFT;
              w_op_nxt    = io.op;
              w_w_nxt     = io.a;
              w_cnt_nxt   = w_n;
            end
          end
          OP_MUL: begin
            w_fin       = 1'b0;
            w_state_nxt = ST_MUL;
            w_op_nxt    = io.op;
            w_a_nxt     = io.a;
            w_w_nxt     = io.b;
            w_hi_nxt    = '0;
            w_cnt_nxt   = CNT_FULL;
          end
          default: w_fill = 1'b1;
        endcase
      end
      ST_SHIFT: begin
        w_w_nxt   = w_sh;
        w_cnt_nxt = r_cnt - 1'b1;
        if (r_cnt == CNT_W'(1)) begin
          w_fin       = 1'b1;
          w_fres      = w_sh;
          w_fc        = w_sh_c;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_MUL: begin
        w_hi_nxt  = w_mhi;
        w_w_nxt   = w_mlo;
        w_cnt_nxt = r_cnt - 1'b1;
        if (r_cnt == CNT_W'(1)) begin
          w_fin       = 1'b1;
          w_fres      = w_mlo;
          w_fhi       = w_mhi;
          w_fv        = (w_mhi != '0);
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (w_fin) begin
      w_done_nxt             = 1'b1;
      w_res_nxt              = w_fres;
      w_reshi_nxt            = w_fhi;
      w_flags_nxt            = '0;
      w_flags_nxt[FLG_ZERO]  = (w_fres == '0);
      w_flags_nxt[FLG_NEG]   = w_fres[WIDTH-1];
      w_flags_nxt[FLG_CARRY] = w_fc;
      w_flags_nxt[FLG_OVF]   = w_fv;
      w_flags_nxt[FLG_ILL]   = w_fill;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_op        <= '0;
      r_a         <= '0;
      r_w         <= '0;
      r_hi        <= '0;
      r_cnt       <= '0;
      r_result    <= '0;
      r_result_hi <= '0;
      r_flags     <= '0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_op        <= w_op_nxt;
      r_a         <= w_a_nxt;
      r_w         <= w_w_nxt;
      r_hi        <= w_hi_nxt;
      r_cnt       <= w_cnt_nxt;
      r_result    <= w_res_nxt;
      r_result_hi <= w_reshi_nxt;
      r_flags     <= w_flags_nxt;
      r_done      <= w_done_nxt;
    end
  end

  assign io.busy      = (r_state != ST_IDLE);
  assign io.done      = r_done;
  assign io.result    = r_result;
  assign io.result_hi = r_result_hi;
  assign io.zero      = r_flags[FLG_ZERO];
  assign io.negative  = r_flags[FLG_NEG];
  assign io.carry     = r_flags[FLG_CARRY];
  assign io.overflow  = r_flags[FLG_OVF];
  assign io.illegal   = r_flags[FLG_ILL];
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: scoreboard bench for seq_alu at WIDTH=8.
// Expected results come from an independent behavioural model.
module tb_seq_alu;
  import alu_pkg::*;

  typedef struct {
    logic [20:0] v;
    int          lat;
  } exp_t;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;
  exp_t sb[$];

  seq_alu_if #(.WIDTH(8)) io ();

  seq_alu #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .io  (io.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [20:0] obs();
    return {io.result, io.result_hi, io.illegal,
            io.overflow, io.carry, io.negative, io.zero};
  endfunction

  // {result, result_hi, illegal, overflow, carry, negative, zero}
  function automatic exp_t model(input logic [4:0] op,
                                 input logic [7:0] a,
                                 input logic [7:0] b);
    exp_t        e;
    logic [7:0]  r, h;
    logic        c, v, il;
    logic [8:0]  s;
    logic [15:0] p;
    int          n;
    r = 8'h00; h = 8'h00; c = 1'b0; v = 1'b0; il = 1'b0;
    s = '0; p = '0; n = 0;
    e.lat = 0;
    case (op)
      OP_NOP:   r = 8'h00;
      OP_WRITE: r = b;
      OP_READ,
      OP_COPY:  r = a;
      OP_NOT:   r = ~a;
      OP_AND:   r = a & b;
      OP_OR:    r = a | b;
      OP_XOR:   r = a ^ b;
      OP_NAND:  r = ~(a & b);
      OP_NOR:   r = ~(a | b);
      OP_ADD, OP_ADDI: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[7:0];
        c = s[8];
        v = (a[7] == b[7]) && (r[7] != a[7]);
      end
      OP_SUB, OP_SUBI: begin
        r = a - b;
        c = (a < b);
        v = (a[7] != b[7]) && (r[7] != a[7]);
      end
      OP_SHL, OP_SHR, OP_ASR: begin
        n = (b >= 8'd8) ? 8 : int'(b);
        e.lat = n;
        r = a;
        if (n > 0) begin
          if (op == OP_SHL) begin
            r = (n == 8) ? 8'h00 : (a << n);
            c = a[8-n];
          end else if (op == OP_SHR) begin
            r = (n == 8) ? 8'h00 : (a >> n);
            c = a[n-1];
          end else begin
            r = $signed(a) >>> n;
            c = a[n-1];
          end
        end
      end
      OP_ROL, OP_ROR: begin
        n = int'(b[2:0]);
        e.lat = n;
        r = a;
        if (n > 0) begin
          if (op == OP_ROL) begin
            r = (a << n) | (a >> (8 - n));
            c = r[0];
          end else begin
            r = (a >> n) | (a << (8 - n));
            c = r[7];
          end
        end
      end
      OP_MUL: begin
        p = {8'h00, a} * {8'h00, b};
        r = p[7:0];
        h = p[15:8];
        v = (h != 8'h00);
        e.lat = 8;
      end
      default: il = 1'b1;
    endcase
    e.v = {r, h, il, v, c, r[7], (r == 8'h00)};
    return e;
  endfunction

  // Called just after a rising edge with the DUT idle; returns
  // just after the accepting edge.
  task automatic issue(input logic [4:0] op,
                       input logic [7:0] a,
                       input logic [7:0] b);
    io.start = 1'b1;
    io.op    = op;
    io.a     = a;
    io.b     = b;
    @(posedge clk); #1;
    io.start = 1'b0;
    io.op    = 5'($urandom);
    io.a     = 8'($urandom);
    io.b     = 8'($urandom);
    sb.push_back(model(op, a, b));
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (io.done !== 1'b1 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic test_reset();
    #12;
    n_chk++;
    if (obs() !== 21'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h want 0", obs());
    end
    n_chk++;
    if (io.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_busy: got %b want 0", io.busy);
    end
    n_chk++;
    if (io.done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_done: got %b want 0", io.done);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_addsub();
    logic [4:0] ops[8];
    logic [7:0] as[8];
    logic [7:0] bs[8];
    exp_t e;
    int   cyc;
    ops = '{OP_ADD, OP_SUB, OP_ADDI, OP_SUBI,
            OP_ADD, OP_SUB, OP_ADD, OP_SUBI};
    as  = '{8'h7F, 8'h00, 8'hFF, 8'h80,
            8'h80, 8'h7F, 8'h12, 8'h55};
    bs  = '{8'h01, 8'h01, 8'h01, 8'h01,
            8'h80, 8'hFF, 8'h34, 8'h55};
    for (int i = 0; i < 8; i++) begin
      issue(ops[i], as[i], bs[i]);
      wait_done(cyc);
      e = sb.pop_front();
      n_chk++;
      if (cyc != e.lat) begin
        n_fail++;
        $display("FAIL addsub_lat[%0d]: got %0d want %0d",
                 i, cyc, e.lat);
      end
      n_chk++;
      if (obs() !== e.v) begin
        n_fail++;
        $display("FAIL addsub_val[%0d]: got %h want %h",
                 i, obs(), e.v);
      end
      n_chk++;
      if (io.busy !== 1'b0) begin
        n_fail++;
        $display("FAIL addsub_busy[%0d]: got %b want 0",
                 i, io.busy);
      end
    end
  endtask

  task automatic test_logic();
    exp_t       e;
    int         cyc;
    logic [7:0] a, b;
    for (int i = 0; i < 10; i++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      issue(5'(i), a, b);
      wait_done(cyc);
      e = sb.pop_front();
      n_chk++;
      if (cyc != e.lat || obs() !== e.v) begin
        n_fail++;
        $display("FAIL logic_op%0d: got %h lat %0d want %h lat %0d",
                 i, obs(), cyc, e.v, e.lat);
      end
    end
  endtask

  task automatic test_shift();
    logic [4:0] ops[7];
    logic [7:0] as[7];
    logic [7:0] bs[7];
    logic [7:0] cnts[5];
    exp_t       e;
    int         cyc;
    ops  = '{OP_ASR, OP_ROL, OP_SHL, OP_SHR,
             OP_ROR, OP_SHL, OP_ASR};
    as   = '{8'h90, 8'h81, 8'hA5, 8'hA5,
             8'h01, 8'hC3, 8'h70};
    bs   = '{8'd9, 8'd9, 8'd0, 8'd200,
             8'd8, 8'd8, 8'd3};
    cnts = '{8'd0, 8'd1, 8'd3, 8'd7, 8'd8};
    for (int i = 0; i < 7; i++) begin
      issue(ops[i], as[i], bs[i]);
      wait_done(cyc);
      e = sb.pop_front();
      n_chk++;
      if (cyc != e.lat) begin
        n_fail++;
        $display("FAIL shift_lat[%0d]: got %0d want %0d",
                 i, cyc, e.lat);
      end
      n_chk++;
      if (obs() !== e.v) begin
        n_fail++;
        $display("FAIL shift_val[%0d]: got %h want %h",
                 i, obs(), e.v);
      end
    end
    for (int o = 0; o < 5; o++) begin
      for (int k = 0; k < 5; k++) begin
        issue(OP_SHL + 5'(o), 8'($urandom), cnts[k]);
        wait_done(cyc);
        e = sb.pop_front();
        n_chk++;
        if (cyc != e.lat || obs() !== e.v) begin
          n_fail++;
          $display("FAIL shift_sweep op%0d n%0d: got %h lat %0d want %h lat %0d",
                   OP_SHL + 5'(o), cnts[k], obs(), cyc, e.v, e.lat);
        end
      end
    end
  endtask

  task automatic test_mul();
    exp_t e;
    int   cyc;
    int   extra;
    issue(OP_MUL, 8'h10, 8'h11);
    cyc = 0;
    while (io.done !== 1'b1 && cyc < 40) begin
      if (cyc == 2) begin
        n_chk++;
        if (io.busy !== 1'b1) begin
          n_fail++;
          $display("FAIL mul_busy: got %b want 1", io.busy);
        end
        io.start = 1'b1;
        io.op    = OP_ADD;
        io.a     = 8'h01;
        io.b     = 8'h01;
      end else begin
        io.start = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    io.start = 1'b0;
    e = sb.pop_front();
    n_chk++;
    if (cyc != e.lat) begin
      n_fail++;
      $display("FAIL mul_lat: got %0d want %0d", cyc, e.lat);
    end
    n_chk++;
    if (obs() !== e.v) begin
      n_fail++;
      $display("FAIL mul_val: got %h want %h", obs(), e.v);
    end
    extra = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (io.done === 1'b1) extra++;
    end
    n_chk++;
    if (extra != 0) begin
      n_fail++;
      $display("FAIL mul_ignored_start: got %0d extra done want 0",
               extra);
    end
    issue(OP_MUL, 8'hFF, 8'hFF);
    wait_done(cyc);
    e = sb.pop_front();
    n_chk++;
    if (cyc != e.lat || obs() !== e.v) begin
      n_fail++;
      $display("FAIL mul_ff: got %h lat %0d want %h lat %0d",
               obs(), cyc, e.v, e.lat);
    end
    issue(OP_MUL, 8'h00, 8'h5A);
    wait_done(cyc);
    e = sb.pop_front();
    n_chk++;
    if (cyc != e.lat || obs() !== e.v) begin
      n_fail++;
      $display("FAIL mul_zero: got %h lat %0d want %h lat %0d",
               obs(), cyc, e.v, e.lat);
    end
  endtask

  task automatic test_reset_mid_mul();
    int extra;
    issue(OP_MUL, 8'h37, 8'h29);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1;
    n_chk++;
    if (obs() !== 21'h0 || io.busy !== 1'b0
        || io.done !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got %h busy %b done %b want 0",
               obs(), io.busy, io.done);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    extra = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (io.done === 1'b1) extra++;
    end
    n_chk++;
    if (extra != 0) begin
      n_fail++;
      $display("FAIL midreset_no_done: got %0d done want 0", extra);
    end
  endtask

  task automatic test_illegal();
    logic [4:0] ops[4];
    logic [7:0] as[4];
    logic [7:0] bs[4];
    exp_t       e;
    int         cyc;
    ops = '{OP_ADD, 5'h1F, 5'd20, 5'd27};
    as  = '{8'h02, 8'hAA, 8'h01, 8'hFF};
    bs  = '{8'h03, 8'h55, 8'h01, 8'hFF};
    for (int i = 0; i < 4; i++) begin
      issue(ops[i], as[i], bs[i]);
      wait_done(cyc);
      e = sb.pop_front();
      n_chk++;
      if (cyc != e.lat || obs() !== e.v) begin
        n_fail++;
        $display("FAIL illegal[%0d]: got %h lat %0d want %h lat %0d",
                 i, obs(), cyc, e.v, e.lat);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] ops[6];
    exp_t       e;
    ops = '{OP_ADD, OP_XOR, OP_SUB, OP_WRITE, OP_NOT, OP_NOR};
    for (int i = 0; i < 6; i++) begin
      issue(ops[i], 8'($urandom), 8'($urandom));
      e = sb.pop_front();
      n_chk++;
      if (io.done !== 1'b1 || obs() !== e.v) begin
        n_fail++;
        $display("FAIL b2b[%0d]: done %b got %h want %h",
                 i, io.done, obs(), e.v);
      end
    end
    @(posedge clk); #1;
    n_chk++;
    if (io.done !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_done_drop: got %b want 0", io.done);
    end
  endtask

  initial begin
    n_chk    = 0;
    n_fail   = 0;
    rst      = 1'b1;
    io.start = 1'b0;
    io.op    = '0;
    io.a     = '0;
    io.b     = '0;
    test_reset();
    test_addsub();
    test_logic();
    test_shift();
    test_mul();
    test_reset_mid_mul();
    test_illegal();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
